// File: rtl/rcrc_edge_reg.sv
// Serial CRC register for the CAN bit-stream path: WIDTH-bit LFSR stepped once per
// rising edge of the bit strobe, with divide/shift-out modes, clear, zero flag and step counter.
module rcrc_edge_reg #(
    parameter int               WIDTH = 15,
    parameter logic [WIDTH-1:0] POLY  = 15'h4599,
    parameter int               CNTW  = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             bitin,
    input  logic             mode,
    input  logic             clear,
    output logic [WIDTH-1:0] crc,
    output logic             crc_zero,
    output logic             serout,
    output logic [CNTW-1:0]  step_cnt,
    output logic             step_done
);

    logic [WIDTH-1:0] crc_q, crc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             edge_q, edge_d;
    logic             step;
    logic [WIDTH-1:0] shifted;

    // The edge flag tracks the strobe level, so a strobe held high yields a single step.
    // It keeps updating under clear, which is what consumes an edge discarded by clear.
    always_comb begin
        step    = enable & ~edge_q;
        edge_d  = edge_q;
        shifted = {crc_q[WIDTH-2:0], 1'b0};
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (step) begin
            edge_d = 1'b1;
        end else if (!enable) begin
            edge_d = 1'b0;
        end

        if (clear) begin
            crc_d = '0;
            cnt_d = '0;
        end else if (step) begin
            if (!mode && (bitin ^ crc_q[WIDTH-1])) begin
                crc_d = shifted ^ POLY;
            end else begin
                crc_d = shifted;
            end
            if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            crc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            edge_q <= edge_d;
        end
    end

    assign crc       = crc_q;
    assign crc_zero  = (crc_q == '0);
    assign serout    = crc_q[WIDTH-1];
    assign step_cnt  = cnt_q;
    assign step_done = done_q;

endmodule

// File: tb/tb_rcrc_edge_reg.sv
// Self-checking bench for rcrc_edge_reg: vector table for the first steps, a scoreboard
// popped on every step_done, and hand-written sequences for shift-out, clear, reset and saturation.
module tb_rcrc_edge_reg;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, reset3, enable, bitin, mode, clear;
    logic [14:0] crc, crc3;
    logic        crc_zero, serout, step_done;
    logic        crc_zero3, serout3, step_done3;
    logic [6:0]  step_cnt;
    logic [2:0]  step_cnt3;

    rcrc_edge_reg dut (
        .clock(clock), .reset(reset), .enable(enable), .bitin(bitin), .mode(mode),
        .clear(clear), .crc(crc), .crc_zero(crc_zero), .serout(serout),
        .step_cnt(step_cnt), .step_done(step_done)
    );

    rcrc_edge_reg #(.WIDTH(15), .POLY(15'h4599), .CNTW(3)) dut3 (
        .clock(clock), .reset(reset3), .enable(enable), .bitin(bitin), .mode(mode),
        .clear(clear), .crc(crc3), .crc_zero(crc_zero3), .serout(serout3),
        .step_cnt(step_cnt3), .step_done(step_done3)
    );

    typedef struct {
        logic [14:0] crc;
        logic [6:0]  cnt;
    } exp_t;

    typedef struct {
        logic        bitin;
        logic        mode;
        int          hold;
        logic [14:0] crc;
        logic [6:0]  cnt;
        string       name;
    } vec_t;

    exp_t        sb[$];
    exp_t        popped;
    logic [14:0] modelCrc;
    logic [6:0]  modelCnt;
    int          tests = 0;
    int          failures = 0;
    int          doneCount = 0;

    function automatic logic [14:0] crcStep(input logic [14:0] c, input logic b, input logic m);
        logic [14:0] s;
        s = {c[13:0], 1'b0};
        if (!m && (b ^ c[14])) s = s ^ 15'h4599;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raises the strobe for 'hold' cycles, then keeps it low one cycle so the next call is a fresh edge.
    task automatic applyStimulus(input logic b, input logic m, input int hold);
        bitin  = b;
        mode   = m;
        enable = 1'b1;
        modelCrc = crcStep(modelCrc, b, m);
        if (modelCnt != 7'h7f) modelCnt = modelCnt + 7'd1;
        sb.push_back('{modelCrc, modelCnt});
        repeat (hold) tick();
        enable = 1'b0;
        tick();
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        modelCrc = '0;
        modelCnt = '0;
    endtask

    always @(negedge clock) begin
        if (step_done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected step_done", {31'd0, step_done}, 32'd0);
            end else begin
                popped = sb.pop_front();
                checkOutput("sb crc", {17'd0, crc}, {17'd0, popped.crc});
                checkOutput("sb step_cnt", {25'd0, step_cnt}, {25'd0, popped.cnt});
                checkOutput("sb crc_zero", {31'd0, crc_zero}, {31'd0, popped.crc == 15'd0});
                checkOutput("sb serout", {31'd0, serout}, {31'd0, popped.crc[14]});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[3];
        int          doneBefore;
        logic [14:0] expBits;
        logic [10:0] msg;
        logic [14:0] rem;

        vecs[0] = '{1'b1, 1'b0, 1,  15'h4599, 7'd1, "T1"};
        vecs[1] = '{1'b0, 1'b0, 1,  15'h4EAB, 7'd2, "T2"};
        vecs[2] = '{1'b1, 1'b0, 10, 15'h1D56, 7'd3, "T3"};

        reset = 1'b0; reset3 = 1'b0; enable = 1'b0; bitin = 1'b0; mode = 1'b0; clear = 1'b0;
        modelCrc = '0;
        modelCnt = '0;
        repeat (3) tick();
        checkOutput("reset crc", {17'd0, crc}, 32'd0);
        checkOutput("reset step_cnt", {25'd0, step_cnt}, 32'd0);
        checkOutput("reset step_done", {31'd0, step_done}, 32'd0);
        checkOutput("reset crc_zero", {31'd0, crc_zero}, 32'd1);
        checkOutput("reset serout", {31'd0, serout}, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            doneBefore = doneCount;
            applyStimulus(vecs[i].bitin, vecs[i].mode, vecs[i].hold);
            checkOutput({vecs[i].name, " crc"}, {17'd0, crc}, {17'd0, vecs[i].crc});
            checkOutput({vecs[i].name, " step_cnt"}, {25'd0, step_cnt}, {25'd0, vecs[i].cnt});
            checkOutput({vecs[i].name, " crc_zero"}, {31'd0, crc_zero}, 32'd0);
            checkOutput({vecs[i].name, " done pulses"}, doneCount - doneBefore, 32'd1);
        end

        // T4: serialise 4EAB out MSB-first; bitin toggles to show it is ignored
        doClear();
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("T4 preload crc", {17'd0, crc}, 32'h4EAB);
        expBits = 15'h4EAB;
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("T4 serout bit %0d", i), {31'd0, serout}, {31'd0, expBits[14-i]});
            applyStimulus(i[0], 1'b1, 1);
        end
        checkOutput("T4 crc", {17'd0, crc}, 32'd0);
        checkOutput("T4 crc_zero", {31'd0, crc_zero}, 32'd1);

        // T5: message followed by its own CRC divides to zero
        doClear();
        msg = 11'h5A5;
        for (int i = 10; i >= 0; i--) applyStimulus(msg[i], 1'b0, 1);
        rem = modelCrc;
        for (int i = 14; i >= 0; i--) applyStimulus(rem[i], 1'b0, 1);
        checkOutput("T5 crc", {17'd0, crc}, 32'd0);
        checkOutput("T5 crc_zero", {31'd0, crc_zero}, 32'd1);
        checkOutput("T5 step_cnt", {25'd0, step_cnt}, 32'd26);

        // T6a: clear coincident with a rising strobe discards and consumes that edge
        applyStimulus(1'b1, 1'b0, 1);
        doneBefore = doneCount;
        bitin = 1'b1; mode = 1'b0; enable = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        modelCrc = '0;
        modelCnt = '0;
        tick();
        enable = 1'b0;
        tick();
        tick();
        checkOutput("T6 clear crc", {17'd0, crc}, 32'd0);
        checkOutput("T6 clear step_cnt", {25'd0, step_cnt}, 32'd0);
        checkOutput("T6 clear crc_zero", {31'd0, crc_zero}, 32'd1);
        checkOutput("T6 clear done pulses", doneCount - doneBefore, 32'd0);

        // T6b: reset mid-stream, with a strobe edge arriving on the reset cycle
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        enable = 1'b1; bitin = 1'b1; mode = 1'b0; reset = 1'b0;
        tick();
        checkOutput("T6 reset crc", {17'd0, crc}, 32'd0);
        checkOutput("T6 reset step_cnt", {25'd0, step_cnt}, 32'd0);
        checkOutput("T6 reset step_done", {31'd0, step_done}, 32'd0);
        checkOutput("T6 reset crc_zero", {31'd0, crc_zero}, 32'd1);
        checkOutput("T6 reset serout", {31'd0, serout}, 32'd0);
        // strobe still high on the first cycle after release counts as a rising edge
        reset = 1'b1;
        modelCrc = crcStep(15'd0, 1'b1, 1'b0);
        modelCnt = 7'd1;
        sb.push_back('{modelCrc, modelCnt});
        tick();
        enable = 1'b0;
        tick();
        checkOutput("T6 post-reset crc", {17'd0, crc}, 32'h4599);
        checkOutput("T6 post-reset step_cnt", {25'd0, step_cnt}, 32'd1);

        // T6c: 3-bit counter saturates at 7
        doClear();
        reset3 = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i[0], 1'b0, 1);
            if (i == 5) checkOutput("T6 cnt3 after 6", {29'd0, step_cnt3}, 32'd6);
        end
        checkOutput("T6 cnt3 saturated", {29'd0, step_cnt3}, 32'd7);
        checkOutput("T6 crc3", {17'd0, crc3}, {17'd0, modelCrc});
        checkOutput("T6 step_cnt 9 steps", {25'd0, step_cnt}, 32'd9);

        tick();
        checkOutput("scoreboard drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
